// File: rtl/uart_word_tx.sv
// Word-to-UART serialiser: sends a TX_WIDTH-bit word as TX_WIDTH/8 8N1 frames, LSB byte first.
// Optional even parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_word_tx #(
  parameter int unsigned TX_WIDTH     = 32,
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic                clk_i,
  input  logic                rst_in,
  input  logic                tx_stb_i,
  input  logic [TX_WIDTH-1:0] tx_i,
  output logic                tx_rdy_o,
  output logic                tx_o
);

  localparam int unsigned NBYTES = TX_WIDTH / 8;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W = $clog2(NBYTES) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e              state_q;
  logic [TX_WIDTH-1:0] shift_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_q;
  logic [BYTE_W-1:0]   byte_q;
  logic                tx_q;
  logic                rdy_q;

  logic                bit_end;
  logic [7:0]          cur_byte;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign cur_byte = shift_q[7:0];
  assign tx_o     = tx_q;
  assign tx_rdy_o = rdy_q;

  // Framing FSM; tx_q is loaded with the next bit value on each bit boundary.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      if (state_q != S_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_stb_i) begin
            shift_q <= tx_i;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q    <= cur_byte[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= ^cur_byte;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (byte_q == BYTE_LAST) begin
              rdy_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              // next byte follows immediately, no idle gap
              shift_q <= shift_q >> 8;
              byte_q  <= byte_q + BYTE_W'(1);
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: stimulus queues expected bytes, a line decoder checks frames.
module tb_uart_word_tx;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned BITS = 11;
`else
  localparam int unsigned BITS = 10;
`endif
  localparam int unsigned WORD_LOW = 4 * BITS * CPB;
  localparam int unsigned FRAME    = BITS * CPB;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        tx_stb_i;
  logic [31:0] tx_i;
  logic        tx_rdy_o;
  logic        tx_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   frames_seen = 0;
  int   last_end = 0;
  int   max_gap = 0;
  bit   track_gap = 1'b0;
  exp_t sb[$];

  uart_word_tx #(.TX_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .tx_stb_i(tx_stb_i),
    .tx_i    (tx_i),
    .tx_rdy_o(tx_rdy_o),
    .tx_o    (tx_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      sb.push_back('{d: b, p: ^b});
    end
  endtask

  // Caller is aligned to a negedge; strobe is sampled on the next posedge.
  task automatic strobe(input logic [31:0] w);
    tx_i     = w;
    tx_stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_stb_i = 1'b0;
    check("accept_rdy_low", {31'd0, tx_rdy_o}, 32'd0);
    check("accept_start_bit", {31'd0, tx_o}, 32'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (tx_rdy_o) break;
      n++;
      if (n > 2000) begin
        check("rdy_timeout", 32'(n), 32'(WORD_LOW));
        break;
      end
    end
  endtask

  // Line decoder: samples every cycle of every bit so bit length is verified too.
  task automatic decode_frame();
    logic [10:0] bits;
    logic        stable;
    logic        abort;
    int          sc;
    exp_t        e;
    bits   = '0;
    stable = 1'b1;
    abort  = 1'b0;
    sc     = cyc;
    if (track_gap && (sc - last_end - 1) > max_gap) max_gap = sc - last_end - 1;
    for (int b = 0; b < int'(BITS); b++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk_i);
        if (!rst_in) begin
          abort = 1'b1;
          break;
        end
        if (c == 0) bits[b] = tx_o;
        else if (tx_o !== bits[b]) stable = 1'b0;
      end
      if (abort) break;
    end
    if (abort) return;
    last_end  = cyc;
    track_gap = 1'b1;
    frames_seen++;
    check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("frame_byte", {24'd0, bits[8:1]}, {24'd0, e.d});
      check("frame_bits", {29'd0, bits[0], bits[BITS-1], stable}, 32'b011);
`ifdef UART_TX_PARITY_EN
      check("frame_parity", {31'd0, bits[9]}, {31'd0, e.p});
`endif
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_in === 1'b1 && tx_o === 1'b0) decode_frame();
    end
  end

  initial begin
    int n;
    int quiet;
    rst_in   = 1'b0;
    tx_stb_i = 1'b0;
    tx_i     = '0;

    #7;
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    check("reset_rdy", {31'd0, tx_rdy_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    rst_in = 1'b1;

    // idle line with no strobe
    quiet = 0;
    repeat (200) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || tx_rdy_o !== 1'b1) quiet++;
    end
    check("idle_quiet", 32'(quiet), 32'd0);
    check("idle_frames", 32'(frames_seen), 32'd0);

    // single word, parity bits 0,0,1,0 for this word
    sb.push_back('{d: 8'h78, p: 1'b0});
    sb.push_back('{d: 8'h56, p: 1'b0});
    sb.push_back('{d: 8'h34, p: 1'b1});
    sb.push_back('{d: 8'h12, p: 1'b0});
    @(negedge clk_i);
    strobe(32'h1234_5678);
    wait_idle(n);
    check("single_low_cycles", 32'(n), 32'(WORD_LOW));
    check("single_idle_tx", {31'd0, tx_o}, 32'd1);
    check("single_drained", 32'(sb.size()), 32'd0);

    // strobe while busy is ignored
    push_word(32'h1234_5678);
    strobe(32'h1234_5678);
    fork
      wait_idle(n);
      begin
        repeat (50) @(negedge clk_i);
        tx_i     = 32'hDEAD_BEEF;
        tx_stb_i = 1'b1;
        @(negedge clk_i);
        tx_stb_i = 1'b0;
      end
    join
    check("busy_low_cycles", 32'(n), 32'(WORD_LOW));
    repeat (2) @(negedge clk_i);
    check("busy_no_restart", {31'd0, tx_rdy_o}, 32'd1);
    check("busy_drained", 32'(sb.size()), 32'd0);
    check("busy_frames", 32'(frames_seen), 32'd8);

    // back-to-back words
    repeat (5) @(negedge clk_i);
    track_gap = 1'b0;
    max_gap   = 0;
    sb.push_back('{d: 8'hFF, p: 1'b0});
    sb.push_back('{d: 8'h00, p: 1'b0});
    sb.push_back('{d: 8'h00, p: 1'b0});
    sb.push_back('{d: 8'h00, p: 1'b0});
    repeat (4) sb.push_back('{d: 8'hA5, p: 1'b0});
    strobe(32'h0000_00FF);
    wait_idle(n);
    check("b2b_low_first", 32'(n), 32'(WORD_LOW));
    strobe(32'hA5A5_A5A5);
    wait_idle(n);
    check("b2b_low_second", 32'(n), 32'(WORD_LOW));
    check("b2b_gap_lt_bit", {31'd0, max_gap <= 1}, 32'd1);
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // reset during data bits of byte 2
    repeat (3) @(negedge clk_i);
    push_word(32'h1234_5678);
    strobe(32'h1234_5678);
    repeat (2 * FRAME + 12) @(negedge clk_i);
    #1;
    rst_in = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx_o}, 32'd1);
    check("midreset_rdy", {31'd0, tx_rdy_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    check("midreset_pending", 32'(sb.size()), 32'd2);
    sb.delete();
    rst_in = 1'b1;
    @(negedge clk_i);
    sb.push_back('{d: 8'h01, p: 1'b1});
    sb.push_back('{d: 8'h00, p: 1'b0});
    sb.push_back('{d: 8'h00, p: 1'b0});
    sb.push_back('{d: 8'h00, p: 1'b0});
    strobe(32'h0000_0001);
    wait_idle(n);
    check("post_reset_low", 32'(n), 32'(WORD_LOW));
    repeat (2) @(negedge clk_i);
    check("post_reset_drained", 32'(sb.size()), 32'd0);

    repeat (5) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serialising transmitter between the capture controller and the host UART line. Accepts one TX_WIDTH-bit sample word per strobe and sends it as TX_WIDTH/8 UART frames, least-significant byte first. Drives a ready flag consumed by the controller's readback loop. Sits directly downstream of the controller's tx_stb/tx data outputs and drives the physical TX pin.

## Interface
- TX_WIDTH, 32: bits per accepted word; must be a multiple of 8 and at least 8.
- CLKS_PER_BIT, 100: clock cycles per UART bit; minimum 2.
- clk_i  input  1  system clock, all logic on rising edge.
- rst_in  input  1  reset; asynchronous and active-low.
- tx_stb_i  input  1  start transmission of tx_i; honoured only while tx_rdy_o=1.
- tx_i  input  TX_WIDTH  word to send; sampled on the accepting edge only.
- tx_rdy_o  output  1  transmitter idle and able to accept a word.
- tx_o  output  1  UART serial line, idle high.

## Operation
- Frame format is 8N1: start bit (0), 8 data bits LSB first, stop bit (1). The parity option below adds one bit.
- States:
  - IDLE: tx_o=1, tx_rdy_o=1. tx_stb_i=1 latches tx_i into the shift register, clears the byte and bit counters, and moves to START.
  - START: tx_o=0 for one bit time, then DATA.
  - DATA: tx_o = current byte bit[bit_cnt]. After bit 7, go to PARITY if compiled in, otherwise STOP.
  - PARITY: tx_o = even parity of the current byte for one bit time, then STOP.
  - STOP: tx_o=1 for one bit time.
    - If more bytes remain: shift the word right 8 bits, increment the byte counter, go to START with no idle gap.
    - Otherwise go to IDLE.
- Bit time: a baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit change. Its width is $clog2(CLKS_PER_BIT).
- Byte counter width: $clog2(TX_WIDTH/8)+1.
- tx_stb_i while tx_rdy_o=0 is ignored. No queuing. tx_i changes while busy have no effect.
- A strobe in the same cycle that tx_rdy_o rises is not accepted. Acceptance requires tx_rdy_o=1 at the sampling edge.
- Reset (asynchronous, any time including mid-frame):
  - Immediately forces tx_o=1, tx_rdy_o=1 and state IDLE.
  - Clears all counters and the shift register.
  - The partial frame is abandoned.

## Timing
- Reset values: tx_o=1, tx_rdy_o=1.
- tx_o and tx_rdy_o are registered outputs.
- Accepting edge k: from k onward tx_rdy_o=0 and tx_o=0 (start bit). The controller sampling tx_rdy one cycle after its strobe therefore sees 0.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- BITS = 10, or 11 with parity.
- tx_rdy_o returns to 1 at edge k + (TX_WIDTH/8)·BITS·CLKS_PER_BIT. tx_o is 1 from the start of the last stop bit.
- Back-to-back words: a strobe on the first cycle tx_rdy_o=1 starts the next start bit on that edge. The minimum gap between frames of successive words is therefore 0 bit times.

## Configuration
- UART_TX_PARITY_EN
  - Defined: each frame carries an even-parity bit between data bit 7 and stop. The parity bit is the XOR of the 8 data bits. BITS=11.
  - Undefined: the PARITY state and its logic are not compiled. BITS=10.

## Test plan
- Reset and idle: hold rst_in=0 mid-run, then release.
  - tx_o=1 and tx_rdy_o=1 asynchronously.
  - No line activity for 200 cycles with no strobe.
- Single word: CLKS_PER_BIT=4, no parity, tx_i=0x12345678.
  - Line decodes to bytes 0x78, 0x56, 0x34, 0x12.
  - Each bit lasts 4 cycles.
  - tx_rdy_o low for exactly 160 cycles.
- Busy strobe: second strobe with 0xDEADBEEF at cycle 50 of the first word.
  - Ignored; only 0x12345678 is transmitted.
  - tx_rdy_o timing is unchanged.
- Back-to-back: strobe 0x000000FF, then strobe 0xA5A5A5A5 on the first cycle tx_rdy_o=1.
  - Eight frames sent with no idle bits between them.
  - Bytes 0xFF, 0x00, 0x00, 0x00, then 0xA5 ×4.
- Parity (UART_TX_PARITY_EN), tx_i=0x12345678.
  - Parity bits 0, 0, 1, 0.
  - tx_rdy_o low for 176 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert rst_in during DATA of byte 2.
  - tx_o=1 immediately.
  - After release, a new strobe with 0x00000001 sends a clean 4-byte word.
